// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU datapath and a host/debug port.
// The CPU wins by default; a starvation counter forces a bounded host burst.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int BURST    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d_in,
  input  logic [DW-1:0] ram_d_out
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

  typedef enum logic {CPU_OWN = 1'b0, HOST_OWN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          grant_host;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CPU_OWN;
      wait_cnt    <= '0;
      burst_cnt   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      burst_cnt   <= burst_nxt;
      host_rvalid <= grant_host & ~host_we;
      if (grant_host && !host_we)
        host_rdata <= ram_d_out;
    end
  end

  always_comb begin
    grant_host = 1'b0;
    state_nxt  = state;
    burst_nxt  = burst_cnt;
    wait_nxt   = wait_cnt;
    case (state)
      CPU_OWN: begin
        grant_host = host_req & (~cpu_req | (wait_cnt == WAIT_MAX));
        if (grant_host) begin
          state_nxt = HOST_OWN;
          burst_nxt = BW'(1);
        end
      end
      HOST_OWN: begin
        grant_host = host_req & (burst_cnt < BURST_MAX);
        if (grant_host) begin
          if (burst_cnt != BURST_MAX)
            burst_nxt = burst_cnt + 1'b1;
        end else begin
          // Handing back always gives the CPU this cycle, so bursts never chain.
          state_nxt = CPU_OWN;
          burst_nxt = '0;
        end
      end
      default: state_nxt = CPU_OWN;
    endcase
    if (!host_req || grant_host)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_MAX)
      wait_nxt = wait_cnt + 1'b1;
  end

  assign host_ack  = grant_host;
  assign cpu_stall = cpu_req & grant_host;
  assign cpu_rdata = ram_d_out;
  assign ram_addr  = grant_host ? host_addr  : cpu_addr;
  assign ram_d_in  = grant_host ? host_wdata : cpu_wdata;
  assign ram_we    = grant_host ? host_we    : (cpu_req & cpu_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand sequences, with a RAM model,
// a shadow memory of expected contents and a queue of expected host read data.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MAX_WAIT = 4, BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, ram_d_in, ram_d_out;
  logic          cpu_stall, host_ack, host_rvalid, ram_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_d_in;
  assign ram_d_out = mem[ram_addr[7:0]];

  typedef struct {
    bit rst; bit creq; bit cwe; logic [31:0] caddr; logic [31:0] cwd;
    bit hreq; bit hwe; logic [31:0] haddr; logic [31:0] hwd;
    bit ack; bit stall; int ws; int st;
  } vec_t;

  int            total = 0, bad = 0;
  logic [31:0]   model [logic [31:0]];
  logic [31:0]   rd_q [$];
  logic [31:0]   last_rd = '0;
  vec_t          tbl [$];

  function automatic vec_t mk(bit rst, bit creq, bit cwe, logic [31:0] caddr, logic [31:0] cwd,
                              bit hreq, bit hwe, logic [31:0] haddr, logic [31:0] hwd,
                              bit ack, bit stall, int ws = -1, int st = -1);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.ack = ack; v.stall = stall; v.ws = ws; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    logic exp_we;
    @(negedge clk);
    reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.haddr; host_wdata = v.hwd;
    #1;
    if (!v.rst) begin
      exp_we = v.ack ? v.hwe : (v.creq & v.cwe);
      chk({nm, ".ack"}, 32'(host_ack), 32'(v.ack));
      chk({nm, ".stall"}, 32'(cpu_stall), 32'(v.stall));
      chk({nm, ".ram_we"}, 32'(ram_we), 32'(exp_we));
      chk({nm, ".ram_addr"}, ram_addr, v.ack ? v.haddr : v.caddr);
      if (exp_we) chk({nm, ".ram_d_in"}, ram_d_in, v.ack ? v.hwd : v.cwd);
      if (v.ack && !v.hwe && model.exists(v.haddr)) rd_q.push_back(model[v.haddr]);
      if (!v.ack && v.creq && !v.cwe && model.exists(v.caddr))
        chk({nm, ".cpu_rdata"}, cpu_rdata, model[v.caddr]);
      if (exp_we) begin
        if (v.ack) model[v.haddr] = v.hwd;
        else       model[v.caddr] = v.cwd;
      end
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      rd_q.delete();
      last_rd = '0;
    end
    chk({nm, ".rvalid"}, 32'(host_rvalid), 32'(rd_q.size() != 0));
    if (rd_q.size() != 0) last_rd = rd_q.pop_front();
    chk({nm, ".rdata"}, host_rdata, last_rd);
    if (v.ws >= 0) chk({nm, ".wait_cnt"}, 32'(dut.wait_cnt), v.ws);
    if (v.st >= 0) chk({nm, ".state"}, 32'(dut.state), v.st);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

    // reset, then CPU-only traffic: never stalled, RAM follows the CPU
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0));
    tbl.push_back(mk(0, 1,1,'h40,'h11, 0,0,0,0, 0,0));
    tbl.push_back(mk(0, 1,1,'h44,'h22, 0,0,0,0, 0,0));
    tbl.push_back(mk(0, 1,0,'h40,0,    0,0,0,0, 0,0));
    tbl.push_back(mk(0, 1,0,'h44,0,    0,0,0,0, 0,0, 0, 0));
    // idle CPU: host write then read-back of 0x10
    tbl.push_back(mk(0, 0,0,0,0, 1,1,'h10,'hA5, 1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,0,'h10,0,    1,0));
    tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0,       0,0, -1, 0));
    // contention from reset: forced grant after MAX_WAIT, burst of BURST
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0));
    for (int i = 0; i <= 8; i++)
      tbl.push_back(mk(0, 1,1,'h50,32'hC0 + i, 1,0,'h10,0, (i >= 4 && i <= 7), (i >= 4 && i <= 7),
                       (i == 3) ? 4 : (i == 8) ? 1 : -1, (i == 8) ? 0 : -1));
    tbl.push_back(mk(0, 1,0,'h50,0, 0,0,0,0, 0,0));
    // host drops mid-burst: CPU free at once, ownership returns
    tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0));
    for (int i = 0; i <= 5; i++)
      tbl.push_back(mk(0, 1,1,'h50,32'hD0 + i, 1,0,'h10,0, (i >= 4), (i >= 4), -1, (i == 4) ? 1 : -1));
    tbl.push_back(mk(0, 1,1,'h50,'hD6, 0,0,0,0, 0,0, 0, 0));
    tbl.push_back(mk(0, 1,0,'h50,0, 1,0,'h10,0, 0,0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of a host read burst
    step(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0), "t5rst");
    for (int i = 0; i <= 4; i++)
      step(mk(0, 1,0,'h50,0, 1,0,'h10,0, (i == 4), (i == 4)), $sformatf("t5c%0d", i));
    step(mk(1, 1,0,'h50,0, 1,0,'h10,0, 0,0, 0, 0), "t5c5");
    for (int i = 6; i <= 10; i++)
      step(mk(0, 1,0,'h50,0, 1,0,'h10,0, (i == 10), (i == 10), (i == 9) ? 4 : -1),
           $sformatf("t5c%0d", i));

    // host grabs an idle RAM; CPU wakes mid-burst and its writes are dropped
    step(mk(0, 1,1,'h70,'h55, 0,0,0,0, 0,0), "t6pre");
    step(mk(1, 0,0,0,0, 0,0,0,0, 0,0, 0, 0), "t6rst");
    step(mk(0, 0,0,0,0, 1,1,'h60,'h77, 1,0, -1, 1), "t6c0");
    for (int i = 1; i <= 3; i++)
      step(mk(0, 1,1,'h70, (i == 2) ? 32'hBAD : 32'hE0 + i, 1,1,32'h60 + i,32'h80 + i, 1,1),
           $sformatf("t6c%0d", i));
    step(mk(0, 1,0,'h70,0, 1,0,'h62,0, 0,0, 1, 0), "t6c4");
    step(mk(0, 0,0,0,0, 1,0,'h62,0, 1,0, 0, 1), "t6c5");
    step(mk(0, 0,0,0,0, 1,0,'h60,0, 1,0), "t6c6");
    step(mk(0, 1,0,'h70,0, 0,0,0,0, 0,0), "t6c7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
